// File: rtl/result_pipe.sv
// result_pipe: back-end result pipeline (EXE -> MEM -> WRB).
//
// Carries each issued instruction's destination descriptor and result through
// the EXE, MEM and WRB stages. The DEC bypass/stall logic reads the per-stage
// outputs, and the register-file write port is driven from WRB.
//
// Optional feature: define RESULT_PIPE_PERF_EN to add the retire and bubble
// performance counters (perf_retire_cnt_o, perf_bubble_cnt_o).
//
// Ports:
//   clk, rst_n            core clock (rising edge), async active-low reset
//   dec_*_i               DEC-stage instruction descriptor and stall/kill
//   exe_alu_result_i      EXE computed result (ALU/CSR mux)
//   mem_load_data_i       load data returned in MEM, valid only while not busy
//   mem_busy_i            data memory not ready; freezes EXE/MEM/WRB
//   exe_*_o, mem_*_o,
//   wrb_*_o               per-stage destination, write enable and result
//   rf_w*_o               register-file write port
//   perf_*_o              performance counters (RESULT_PIPE_PERF_EN only)
//   pipe_freeze_o         tells the front end to hold (equals mem_busy_i)
module result_pipe #(
  parameter int unsigned XLEN = 32,
  parameter int unsigned RA_W = 5
) (
  input  logic            clk,
  input  logic            rst_n,
  // DEC side
  input  logic            dec_valid_i,
  input  logic [RA_W-1:0] dec_rd_i,
  input  logic            dec_rd_wenb_i,
  input  logic            dec_load_i,
  input  logic            dec_csr_i,
  input  logic            dec_stall_i,
  input  logic            dec_kill_i,
  // Datapath inputs
  input  logic [XLEN-1:0] exe_alu_result_i,
  input  logic [XLEN-1:0] mem_load_data_i,
  input  logic            mem_busy_i,
  // EXE stage
  output logic [RA_W-1:0] exe_rd_o,
  output logic            exe_rd_wenb_o,
  output logic [XLEN-1:0] exe_result_o,
  output logic            exe_load_o,
  output logic            exe_csr_o,
  // MEM stage
  output logic [RA_W-1:0] mem_rd_o,
  output logic            mem_rd_wenb_o,
  output logic [XLEN-1:0] mem_result_o,
  // WRB stage
  output logic [RA_W-1:0] wrb_rd_o,
  output logic            wrb_rd_wenb_o,
  output logic [XLEN-1:0] wrb_result_o,
  // Register-file write port
  output logic            rf_wenb_o,
  output logic [RA_W-1:0] rf_waddr_o,
  output logic [XLEN-1:0] rf_wdata_o,
`ifdef RESULT_PIPE_PERF_EN
  output logic [31:0]     perf_retire_cnt_o,
  output logic [31:0]     perf_bubble_cnt_o,
`endif
  output logic            pipe_freeze_o
);

  logic advance;
  logic dec_accept;

  // EXE stage state
  logic            exe_valid_q, exe_valid_d;
  logic [RA_W-1:0] exe_rd_q,    exe_rd_d;
  logic            exe_wenb_q,  exe_wenb_d;
  logic            exe_load_q,  exe_load_d;
  logic            exe_csr_q,   exe_csr_d;

  // MEM stage state
  logic            mem_valid_q, mem_valid_d;
  logic [RA_W-1:0] mem_rd_q,    mem_rd_d;
  logic            mem_wenb_q,  mem_wenb_d;
  logic            mem_load_q,  mem_load_d;
  logic [XLEN-1:0] mem_alu_q,   mem_alu_d;
  logic [XLEN-1:0] mem_result;

  // WRB stage state
  logic            wrb_valid_q,  wrb_valid_d;
  logic [RA_W-1:0] wrb_rd_q,     wrb_rd_d;
  logic            wrb_wenb_q,   wrb_wenb_d;
  logic [XLEN-1:0] wrb_result_q, wrb_result_d;

  // A busy data memory stalls every back-end stage at once.
  assign advance    = ~mem_busy_i;
  assign dec_accept = dec_valid_i & ~dec_stall_i & ~dec_kill_i;

  // Load data only exists in MEM, so the MEM result is muxed here rather than captured.
  assign mem_result = mem_load_q ? mem_load_data_i : mem_alu_q;

  always_comb begin
    // Hold by default (freeze).
    exe_valid_d  = exe_valid_q;
    exe_rd_d     = exe_rd_q;
    exe_wenb_d   = exe_wenb_q;
    exe_load_d   = exe_load_q;
    exe_csr_d    = exe_csr_q;
    mem_valid_d  = mem_valid_q;
    mem_rd_d     = mem_rd_q;
    mem_wenb_d   = mem_wenb_q;
    mem_load_d   = mem_load_q;
    mem_alu_d    = mem_alu_q;
    wrb_valid_d  = wrb_valid_q;
    wrb_rd_d     = wrb_rd_q;
    wrb_wenb_d   = wrb_wenb_q;
    wrb_result_d = wrb_result_q;

    if (advance) begin
      // Stalled or killed DEC instructions become a fully cleared bubble.
      exe_valid_d = dec_accept;
      exe_rd_d    = dec_accept ? dec_rd_i : '0;
      // Writes to x0 are dropped at entry so bypass can never match x0.
      exe_wenb_d  = dec_accept & dec_rd_wenb_i & (dec_rd_i != '0);
      exe_load_d  = dec_accept & dec_load_i;
      exe_csr_d   = dec_accept & dec_csr_i;

      mem_valid_d = exe_valid_q;
      mem_rd_d    = exe_rd_q;
      mem_wenb_d  = exe_wenb_q;
      mem_load_d  = exe_load_q;
      mem_alu_d   = exe_alu_result_i;

      wrb_valid_d  = mem_valid_q;
      wrb_rd_d     = mem_rd_q;
      wrb_wenb_d   = mem_wenb_q;
      wrb_result_d = mem_result;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      exe_valid_q  <= 1'b0;
      exe_rd_q     <= '0;
      exe_wenb_q   <= 1'b0;
      exe_load_q   <= 1'b0;
      exe_csr_q    <= 1'b0;
      mem_valid_q  <= 1'b0;
      mem_rd_q     <= '0;
      mem_wenb_q   <= 1'b0;
      mem_load_q   <= 1'b0;
      mem_alu_q    <= '0;
      wrb_valid_q  <= 1'b0;
      wrb_rd_q     <= '0;
      wrb_wenb_q   <= 1'b0;
      wrb_result_q <= '0;
    end else begin
      exe_valid_q  <= exe_valid_d;
      exe_rd_q     <= exe_rd_d;
      exe_wenb_q   <= exe_wenb_d;
      exe_load_q   <= exe_load_d;
      exe_csr_q    <= exe_csr_d;
      mem_valid_q  <= mem_valid_d;
      mem_rd_q     <= mem_rd_d;
      mem_wenb_q   <= mem_wenb_d;
      mem_load_q   <= mem_load_d;
      mem_alu_q    <= mem_alu_d;
      wrb_valid_q  <= wrb_valid_d;
      wrb_rd_q     <= wrb_rd_d;
      wrb_wenb_q   <= wrb_wenb_d;
      wrb_result_q <= wrb_result_d;
    end
  end

  // Stage outputs
  assign exe_rd_o      = exe_rd_q;
  assign exe_rd_wenb_o = exe_wenb_q;
  assign exe_result_o  = exe_alu_result_i;
  assign exe_load_o    = exe_load_q;
  assign exe_csr_o     = exe_csr_q;

  assign mem_rd_o      = mem_rd_q;
  assign mem_rd_wenb_o = mem_wenb_q;
  assign mem_result_o  = mem_result;

  assign wrb_rd_o      = wrb_rd_q;
  assign wrb_rd_wenb_o = wrb_wenb_q;
  assign wrb_result_o  = wrb_result_q;

  // Gating with advance means a frozen WRB entry commits exactly once, on release.
  assign rf_wenb_o  = wrb_wenb_q & wrb_valid_q & advance;
  assign rf_waddr_o = wrb_rd_q;
  assign rf_wdata_o = wrb_result_q;

  assign pipe_freeze_o = mem_busy_i;

`ifdef RESULT_PIPE_PERF_EN
  logic [31:0] perf_retire_q, perf_retire_d;
  logic [31:0] perf_bubble_q, perf_bubble_d;

  always_comb begin
    perf_retire_d = perf_retire_q;
    perf_bubble_d = perf_bubble_q;
    if (advance & wrb_valid_q) begin
      perf_retire_d = perf_retire_q + 32'd1;
    end
    // Only a real DEC instruction turned into a bubble counts.
    if (advance & (dec_stall_i | dec_kill_i) & dec_valid_i) begin
      perf_bubble_d = perf_bubble_q + 32'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_retire_q <= '0;
      perf_bubble_q <= '0;
    end else begin
      perf_retire_q <= perf_retire_d;
      perf_bubble_q <= perf_bubble_d;
    end
  end

  assign perf_retire_cnt_o = perf_retire_q;
  assign perf_bubble_cnt_o = perf_bubble_q;
`endif

endmodule

// File: tb/tb_result_pipe.sv
// tb_result_pipe: directed self-checking bench for result_pipe.
module tb_result_pipe;

  logic        clk;
  logic        rst_n;
  logic        dec_valid, dec_rd_wenb, dec_load, dec_csr, dec_stall, dec_kill;
  logic [4:0]  dec_rd;
  logic [31:0] exe_alu_result, mem_load_data;
  logic        mem_busy;
  logic [4:0]  exe_rd, mem_rd, wrb_rd, rf_waddr;
  logic        exe_rd_wenb, exe_load, exe_csr, mem_rd_wenb, wrb_rd_wenb, rf_wenb;
  logic [31:0] exe_result, mem_result, wrb_result, rf_wdata;
  logic        pipe_freeze;
`ifdef RESULT_PIPE_PERF_EN
  logic [31:0] perf_retire_cnt, perf_bubble_cnt;
`endif

  int n_checks = 0;
  int n_errors = 0;
  int rf_wr1_cnt = 0;

  result_pipe #(
    .XLEN (32),
    .RA_W (5)
  ) u_dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .dec_valid_i      (dec_valid),
    .dec_rd_i         (dec_rd),
    .dec_rd_wenb_i    (dec_rd_wenb),
    .dec_load_i       (dec_load),
    .dec_csr_i        (dec_csr),
    .dec_stall_i      (dec_stall),
    .dec_kill_i       (dec_kill),
    .exe_alu_result_i (exe_alu_result),
    .mem_load_data_i  (mem_load_data),
    .mem_busy_i       (mem_busy),
    .exe_rd_o         (exe_rd),
    .exe_rd_wenb_o    (exe_rd_wenb),
    .exe_result_o     (exe_result),
    .exe_load_o       (exe_load),
    .exe_csr_o        (exe_csr),
    .mem_rd_o         (mem_rd),
    .mem_rd_wenb_o    (mem_rd_wenb),
    .mem_result_o     (mem_result),
    .wrb_rd_o         (wrb_rd),
    .wrb_rd_wenb_o    (wrb_rd_wenb),
    .wrb_result_o     (wrb_result),
    .rf_wenb_o        (rf_wenb),
    .rf_waddr_o       (rf_waddr),
    .rf_wdata_o       (rf_wdata),
`ifdef RESULT_PIPE_PERF_EN
    .perf_retire_cnt_o(perf_retire_cnt),
    .perf_bubble_cnt_o(perf_bubble_cnt),
`endif
    .pipe_freeze_o    (pipe_freeze)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Counts committed RF writes to x1 (commit decided at the following rising edge).
  always @(negedge clk) begin
    if (rst_n && rf_wenb && rf_waddr == 5'd1) rf_wr1_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [4:0] rd, input logic we, input logic ld,
                       input logic csr, input logic st, input logic kl);
    dec_valid   = v;
    dec_rd      = rd;
    dec_rd_wenb = we;
    dec_load    = ld;
    dec_csr     = csr;
    dec_stall   = st;
    dec_kill    = kl;
  endtask

  task automatic idle();
    drive(1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic do_reset();
    idle();
    mem_busy = 1'b0;
    rst_n    = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n          = 1'b0;
    exe_alu_result = '0;
    mem_load_data  = '0;
    mem_busy       = 1'b0;
    idle();
    #1;
    // Reset state
    check("rst_exe_wenb", {31'd0, exe_rd_wenb}, 32'd0);
    check("rst_exe_rd", {27'd0, exe_rd}, 32'd0);
    check("rst_mem_wenb", {31'd0, mem_rd_wenb}, 32'd0);
    check("rst_wrb_wenb", {31'd0, wrb_rd_wenb}, 32'd0);
    check("rst_wrb_result", wrb_result, 32'd0);
    check("rst_rf_wenb", {31'd0, rf_wenb}, 32'd0);
    check("rst_freeze", {31'd0, pipe_freeze}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // ADD rd=5 -> 0x1234 with CSR flag
    drive(1'b1, 5'd5, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    step();
    check("add_exe_rd", {27'd0, exe_rd}, 32'd5);
    check("add_exe_wenb", {31'd0, exe_rd_wenb}, 32'd1);
    check("add_exe_csr", {31'd0, exe_csr}, 32'd1);
    idle();
    exe_alu_result = 32'h0000_1234;
    #1;
    check("add_exe_result", exe_result, 32'h0000_1234);
    step();
    exe_alu_result = 32'h0;
    #1;
    check("add_mem_rd", {27'd0, mem_rd}, 32'd5);
    check("add_mem_result", mem_result, 32'h0000_1234);
    check("add_exe_bubble", {31'd0, exe_rd_wenb}, 32'd0);
    step();
    check("add_rf_wenb", {31'd0, rf_wenb}, 32'd1);
    check("add_rf_waddr", {27'd0, rf_waddr}, 32'd5);
    check("add_rf_wdata", rf_wdata, 32'h0000_1234);
    step();
    check("add_rf_wenb_after", {31'd0, rf_wenb}, 32'd0);

    // rd=0 write is squashed at every stage
    drive(1'b1, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    step();
    idle();
    check("x0_exe_wenb", {31'd0, exe_rd_wenb}, 32'd0);
    step();
    check("x0_mem_wenb", {31'd0, mem_rd_wenb}, 32'd0);
    step();
    check("x0_wrb_wenb", {31'd0, wrb_rd_wenb}, 32'd0);
    check("x0_rf_wenb", {31'd0, rf_wenb}, 32'd0);

    // Load rd=7
    drive(1'b1, 5'd7, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    step();
    check("ld_exe_load", {31'd0, exe_load}, 32'd1);
    idle();
    exe_alu_result = 32'h0000_0055;
    step();
    check("ld_exe_load_gone", {31'd0, exe_load}, 32'd0);
    mem_load_data  = 32'hDEAD_BEEF;
    exe_alu_result = 32'h0;
    #1;
    check("ld_mem_result", mem_result, 32'hDEAD_BEEF);
    step();
    mem_load_data = 32'h0;
    check("ld_rf_wenb", {31'd0, rf_wenb}, 32'd1);
    check("ld_rf_waddr", {27'd0, rf_waddr}, 32'd7);
    check("ld_rf_wdata", rf_wdata, 32'hDEAD_BEEF);

    // Stall, normal, stall+kill, kill
    drive(1'b1, 5'd3, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    step();
    check("stall_exe_wenb", {31'd0, exe_rd_wenb}, 32'd0);
    check("stall_exe_rd", {27'd0, exe_rd}, 32'd0);
    drive(1'b1, 5'd4, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    step();
    check("post_stall_exe_rd", {27'd0, exe_rd}, 32'd4);
    check("post_stall_exe_wenb", {31'd0, exe_rd_wenb}, 32'd1);
    drive(1'b1, 5'd6, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
    step();
    check("stkill_exe_wenb", {31'd0, exe_rd_wenb}, 32'd0);
    check("stkill_exe_load", {31'd0, exe_load}, 32'd0);
    drive(1'b1, 5'd6, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    step();
    check("kill_exe_wenb", {31'd0, exe_rd_wenb}, 32'd0);
    idle();
    step();
    step();
    step();

    // Freeze for 3 cycles with all stages full
    rf_wr1_cnt = 0;
    drive(1'b1, 5'd1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    exe_alu_result = 32'h0;
    step();
    drive(1'b1, 5'd2, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    exe_alu_result = 32'h11;
    step();
    drive(1'b1, 5'd3, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    exe_alu_result = 32'h22;
    step();
    drive(1'b1, 5'd9, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    exe_alu_result = 32'h33;
    mem_busy       = 1'b1;
    #1;
    check("frz_freeze", {31'd0, pipe_freeze}, 32'd1);
    for (int i = 0; i < 3; i++) begin
      step();
      check("frz_exe_rd", {27'd0, exe_rd}, 32'd3);
      check("frz_mem_rd", {27'd0, mem_rd}, 32'd2);
      check("frz_mem_result", mem_result, 32'h22);
      check("frz_wrb_rd", {27'd0, wrb_rd}, 32'd1);
      check("frz_wrb_result", wrb_result, 32'h11);
      check("frz_rf_wenb", {31'd0, rf_wenb}, 32'd0);
    end
    mem_busy = 1'b0;
    idle();
    #1;
    check("rel_freeze", {31'd0, pipe_freeze}, 32'd0);
    check("rel_rf_wenb", {31'd0, rf_wenb}, 32'd1);
    check("rel_rf_waddr", {27'd0, rf_waddr}, 32'd1);
    check("rel_rf_wdata", rf_wdata, 32'h11);
    step();
    check("rel_wrb_rd", {27'd0, wrb_rd}, 32'd2);
    check("rel_rf_wdata2", rf_wdata, 32'h22);
    check("rel_mem_rd", {27'd0, mem_rd}, 32'd3);
    check("rel_mem_result", mem_result, 32'h33);
    check("rel_exe_bubble", {31'd0, exe_rd_wenb}, 32'd0);
    step();
    step();
    check("rel_x1_write_once", rf_wr1_cnt, 32'd1);

    // Reset mid-operation discards in-flight entries
    drive(1'b1, 5'd10, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    step();
    step();
    step();
    rst_n = 1'b0;
    #1;
    check("mrst_exe_rd", {27'd0, exe_rd}, 32'd0);
    check("mrst_mem_wenb", {31'd0, mem_rd_wenb}, 32'd0);
    check("mrst_wrb_wenb", {31'd0, wrb_rd_wenb}, 32'd0);
    check("mrst_rf_wenb", {31'd0, rf_wenb}, 32'd0);
    step();
    check("mrst_rf_wenb_held", {31'd0, rf_wenb}, 32'd0);
    idle();
    @(negedge clk);
    rst_n = 1'b1;

`ifdef RESULT_PIPE_PERF_EN
    do_reset();
    check("perf_rst_retire", perf_retire_cnt, 32'd0);
    drive(1'b1, 5'd1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    step();
    drive(1'b1, 5'd2, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    step();
    drive(1'b1, 5'd2, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    step();
    drive(1'b1, 5'd3, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    step();
    drive(1'b1, 5'd4, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    step();
    drive(1'b1, 5'd4, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    step();
    idle();
    step();
    step();
    step();
    check("perf_retire", perf_retire_cnt, 32'd4);
    check("perf_bubble", perf_bubble_cnt, 32'd2);
    step();
    check("perf_retire_stable", perf_retire_cnt, 32'd4);
    drive(1'b1, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    step();
    rst_n = 1'b0;
    #1;
    check("perf_mrst_retire", perf_retire_cnt, 32'd0);
    check("perf_mrst_bubble", perf_bubble_cnt, 32'd0);
    idle();
    @(negedge clk);
    rst_n = 1'b1;
`endif

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
